// File: rtl/sdr_pkg.sv
// -----------------------------------------------------------------------------
// sdr_pkg
// Shared definitions for the SDRAM init/refresh sequencer:
//   - command encodings driven on {ras, cas, we} (active low)
//   - sequencer FSM state enumeration
//   - mode-register field positions and the PRECHARGE ALL address bit
//   - a small constant helper used to size counters
// -----------------------------------------------------------------------------
package sdr_pkg;

  localparam logic [2:0] CMD_NOP  = 3'b111;
  localparam logic [2:0] CMD_PRE  = 3'b010;
  localparam logic [2:0] CMD_AREF = 3'b001;
  localparam logic [2:0] CMD_MRS  = 3'b000;

  // Mode register layout: BL[2:0], BT[3] (kept 0), CL[6:4], M9 write-burst mode.
  localparam int MR_BL_LSB   = 0;
  localparam int MR_CL_LSB   = 4;
  localparam int MR_M9_BIT   = 9;
  localparam int PRE_ALL_BIT = 10;

  typedef enum logic [3:0] {
    PWR,
    PRE,
    PRE_W,
    AREF,
    AREF_W,
    MRS,
    MRS_W,
    IDLE,
    RPRE,
    RPRE_W,
    RREF,
    RREF_W
  } sdr_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sdr_ref_sched.sv
// -----------------------------------------------------------------------------
// sdr_ref_sched
// Refresh credit scheduler: an interval counter that runs only while `run`
// is high and a saturating pending-refresh counter.
// Ports:
//   Sdr_clk, Rst   clock, asynchronous active-high reset
//   run            interval counter enable (init done)
//   inc_app        one-cycle application refresh credit
//   dec            one refresh issued this cycle
//   req            registered: pending > 0 while run
//   urgent         registered: pending == MAX_POSTPONE
//   pend           registered pending count
// -----------------------------------------------------------------------------
module sdr_ref_sched #(
  parameter int REF_INTERVAL = 780,
  parameter int MAX_POSTPONE = 8,
  parameter int SELF_REF_EN  = 1
) (
  input  logic       Sdr_clk,
  input  logic       Rst,
  input  logic       run,
  input  logic       inc_app,
  input  logic       dec,
  output logic       req,
  output logic       urgent,
  output logic [3:0] pend
);

  localparam int IW = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;

  logic [IW-1:0] ivl_cnt;
  logic          wrap;
  logic          inc;
  logic [3:0]    pend_nxt;

  assign wrap = run && (ivl_cnt == IW'(REF_INTERVAL - 1));
  assign inc  = inc_app || (wrap && (SELF_REF_EN != 0));

  // The interval restarts from zero every time init completes.
  always_ff @(posedge Sdr_clk or posedge Rst) begin
    if (Rst)                ivl_cnt <= '0;
    else if (!run || wrap)  ivl_cnt <= '0;
    else                    ivl_cnt <= ivl_cnt + IW'(1);
  end

  // A credit and a decrement in the same cycle cancel each other.
  always_comb begin
    pend_nxt = pend;
    if (inc && !dec) begin
      if (pend != 4'(MAX_POSTPONE)) pend_nxt = pend + 4'd1;
    end else if (dec && !inc) begin
      if (pend != 4'd0) pend_nxt = pend - 4'd1;
    end
  end

  always_ff @(posedge Sdr_clk or posedge Rst) begin
    if (Rst) begin
      pend   <= 4'd0;
      req    <= 1'b0;
      urgent <= 1'b0;
    end else begin
      pend   <= pend_nxt;
      req    <= run && (pend_nxt != 4'd0);
      urgent <= (pend_nxt == 4'(MAX_POSTPONE));
    end
  end

endmodule

// File: rtl/sdr_init_ref_ctrl.sv
// -----------------------------------------------------------------------------
// sdr_init_ref_ctrl
// SDRAM power-up initialisation and auto-refresh sequencer. Owns the shared
// command bus (Sdr_init_ref_vld) from the first PRECHARGE to the end of the
// last wait of an init or refresh sequence; drives NOP with zero ba/addr
// otherwise.
// Ports:
//   Sdr_clk, Rst          clock, asynchronous active-high reset
//   Sdr_init_req          re-initialisation pulse (honoured in IDLE only)
//   Sdr_init_mode         [2:0] burst length, [3] M9
//   Sdr_init_done         high once the mode register wait completes
//   App_ref_req           application refresh credit pulse
//   Sdr_ref_req/urgent    refresh request / pending counter saturated
//   Sdr_ref_pend          pending refresh count
//   Sdr_ref_ack           arbiter grant pulse
//   Sdr_rw_vld            read/write engine currently owns the bus
//   Sdr_init_ref_*        registered command bus outputs
// -----------------------------------------------------------------------------
module sdr_init_ref_ctrl
  import sdr_pkg::*;
#(
  parameter int ROW_WIDTH    = 12,
  parameter int BA_WIDTH     = 2,
  parameter int PWR_WAIT     = 20000,
  parameter int T_RP         = 3,
  parameter int T_RFC        = 7,
  parameter int T_MRD        = 2,
  parameter int INIT_REF_NUM = 8,
  parameter int CAS_LAT      = 3,
  parameter int REF_INTERVAL = 780,
  parameter int MAX_POSTPONE = 8,
  parameter int SELF_REF_EN  = 1
) (
  input  logic                  Sdr_clk,
  input  logic                  Rst,
  input  logic                  Sdr_init_req,
  input  logic [3:0]            Sdr_init_mode,
  output logic                  Sdr_init_done,
  input  logic                  App_ref_req,
  output logic                  Sdr_ref_req,
  output logic                  Sdr_ref_urgent,
  output logic [3:0]            Sdr_ref_pend,
  input  logic                  Sdr_ref_ack,
  input  logic                  Sdr_rw_vld,
  output logic                  Sdr_init_ref_vld,
  output logic                  Sdr_init_ref_ras,
  output logic                  Sdr_init_ref_cas,
  output logic                  Sdr_init_ref_we,
  output logic [BA_WIDTH-1:0]   Sdr_init_ref_ba,
  output logic [ROW_WIDTH:0]    Sdr_init_ref_addr
);

  localparam int WAIT_MAX = max2(max2(PWR_WAIT, T_RP), max2(T_RFC, T_MRD));
  localparam int WW       = $clog2(WAIT_MAX + 1);
  localparam int LW       = $clog2(INIT_REF_NUM + 1);

  sdr_state_t        state, state_nxt;
  logic [WW-1:0]     wait_cnt;
  logic [LW-1:0]     aref_cnt;
  logic              done_q, done_nxt;
  logic              vld_q;
  logic [2:0]        cmd_q, cmd_nxt;
  logic [ROW_WIDTH:0] addr_q, addr_nxt;
  logic [3:0]        ref_pend;
  logic              ref_dec;

  function automatic logic [ROW_WIDTH:0] mode_word(input logic [3:0] mode);
    logic [ROW_WIDTH:0] mr;
    mr                    = '0;
    mr[MR_BL_LSB +: 3]    = mode[2:0];
    mr[MR_CL_LSB +: 3]    = 3'(CAS_LAT);
    mr[MR_M9_BIT]         = mode[3];
    return mr;
  endfunction

  sdr_ref_sched #(
    .REF_INTERVAL (REF_INTERVAL),
    .MAX_POSTPONE (MAX_POSTPONE),
    .SELF_REF_EN  (SELF_REF_EN)
  ) u_sched (
    .Sdr_clk (Sdr_clk),
    .Rst     (Rst),
    .run     (done_q),
    .inc_app (App_ref_req),
    .dec     (ref_dec),
    .req     (Sdr_ref_req),
    .urgent  (Sdr_ref_urgent),
    .pend    (ref_pend)
  );

  // The pending count drops as each refresh command leaves the bus.
  assign ref_dec = (state == RREF);

  always_comb begin
    state_nxt = state;
    done_nxt  = done_q;
    case (state)
      PWR:    if (wait_cnt == WW'(PWR_WAIT)) state_nxt = PRE;
      PRE:    state_nxt = PRE_W;
      PRE_W:  if (wait_cnt == WW'(T_RP - 1)) state_nxt = AREF;
      AREF:   state_nxt = AREF_W;
      AREF_W: if (wait_cnt == WW'(T_RFC - 1))
                state_nxt = (aref_cnt == LW'(INIT_REF_NUM)) ? MRS : AREF;
      MRS:    state_nxt = MRS_W;
      MRS_W:  if (wait_cnt == WW'(T_MRD - 1)) begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
              end
      IDLE:   if (Sdr_init_req) begin
                // Re-init takes priority over a coincident grant.
                state_nxt = PRE;
                done_nxt  = 1'b0;
              end else if (Sdr_ref_ack && !Sdr_rw_vld && (ref_pend != 4'd0)) begin
                state_nxt = RPRE;
              end
      RPRE:   state_nxt = RPRE_W;
      RPRE_W: if (wait_cnt == WW'(T_RP - 1)) state_nxt = RREF;
      RREF:   state_nxt = RREF_W;
      // Credits that land during the drain are drained in the same burst.
      RREF_W: if (wait_cnt == WW'(T_RFC - 1))
                state_nxt = (ref_pend == 4'd0) ? IDLE : RREF;
      default: state_nxt = PWR;
    endcase
  end

  // Outputs are decoded from the next state so the command appears in the
  // same cycle the FSM enters the corresponding state.
  always_comb begin
    cmd_nxt  = CMD_NOP;
    addr_nxt = '0;
    case (state_nxt)
      PRE, RPRE: begin
        cmd_nxt               = CMD_PRE;
        addr_nxt[PRE_ALL_BIT] = 1'b1;
      end
      AREF, RREF: cmd_nxt = CMD_AREF;
      MRS: begin
        cmd_nxt  = CMD_MRS;
        addr_nxt = mode_word(Sdr_init_mode);
      end
      default: ;
    endcase
  end

  always_ff @(posedge Sdr_clk or posedge Rst) begin
    if (Rst) begin
      state    <= PWR;
      wait_cnt <= '0;
      aref_cnt <= '0;
      done_q   <= 1'b0;
      vld_q    <= 1'b0;
      cmd_q    <= CMD_NOP;
      addr_q   <= '0;
    end else begin
      state  <= state_nxt;
      done_q <= done_nxt;
      vld_q  <= (state_nxt != PWR) && (state_nxt != IDLE);
      cmd_q  <= cmd_nxt;
      addr_q <= addr_nxt;
      // Wait counter restarts on every state change; PWR counts from reset.
      if (state_nxt != state)  wait_cnt <= '0;
      else if (state != IDLE)  wait_cnt <= wait_cnt + WW'(1);
      if (state == PRE)        aref_cnt <= '0;
      else if (state == AREF)  aref_cnt <= aref_cnt + LW'(1);
    end
  end

  assign Sdr_init_done     = done_q;
  assign Sdr_ref_pend      = ref_pend;
  assign Sdr_init_ref_vld  = vld_q;
  assign Sdr_init_ref_ras  = cmd_q[2];
  assign Sdr_init_ref_cas  = cmd_q[1];
  assign Sdr_init_ref_we   = cmd_q[0];
  assign Sdr_init_ref_ba   = '0;
  assign Sdr_init_ref_addr = addr_q;

endmodule

// File: tb/tb_sdr_init_ref_ctrl.sv
`timescale 1ns/1ps
module tb_sdr_init_ref_ctrl;

  localparam logic [2:0]  C_NOP  = 3'b111;
  localparam logic [2:0]  C_PRE  = 3'b010;
  localparam logic [2:0]  C_AREF = 3'b001;
  localparam logic [2:0]  C_MRS  = 3'b000;
  localparam logic [12:0] A_PRE  = 13'h400;
  localparam logic [12:0] A_MR0  = 13'h032;  // BL=2, CL=3, M9=0
  localparam logic [12:0] A_MR1  = 13'h233;  // BL=3, CL=3, M9=1

  logic        clk = 1'b0;
  logic        rst;
  logic        init_req = 1'b0;
  logic [3:0]  mode = 4'b0010;
  logic        init_done;
  logic        app_ref = 1'b0;
  logic        ref_req, ref_urgent;
  logic [3:0]  ref_pend;
  logic        ack = 1'b0;
  logic        rw_vld = 1'b0;
  logic        bus_vld, ras, cas, we;
  logic [1:0]  ba;
  logic [12:0] addr;

  always #5 clk = ~clk;

  sdr_init_ref_ctrl #(
    .ROW_WIDTH(12), .BA_WIDTH(2), .PWR_WAIT(16), .T_RP(2), .T_RFC(4), .T_MRD(2),
    .INIT_REF_NUM(2), .CAS_LAT(3), .REF_INTERVAL(50), .MAX_POSTPONE(4), .SELF_REF_EN(1)
  ) dut (
    .Sdr_clk(clk), .Rst(rst), .Sdr_init_req(init_req), .Sdr_init_mode(mode),
    .Sdr_init_done(init_done), .App_ref_req(app_ref), .Sdr_ref_req(ref_req),
    .Sdr_ref_urgent(ref_urgent), .Sdr_ref_pend(ref_pend), .Sdr_ref_ack(ack),
    .Sdr_rw_vld(rw_vld), .Sdr_init_ref_vld(bus_vld), .Sdr_init_ref_ras(ras),
    .Sdr_init_ref_cas(cas), .Sdr_init_ref_we(we), .Sdr_init_ref_ba(ba),
    .Sdr_init_ref_addr(addr)
  );

  typedef struct {
    int          at;
    logic [2:0]  cmd;
    logic [12:0] addr;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   base     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_cmd(input int at, input logic [2:0] c, input logic [12:0] a);
    exp_t e;
    e.at = base + at; e.cmd = c; e.addr = a;
    sbq.push_back(e);
  endtask

  task automatic expect_init(input int p, input logic [12:0] mr);
    expect_cmd(p,      C_PRE,  A_PRE);
    expect_cmd(p + 3,  C_AREF, 13'h000);
    expect_cmd(p + 8,  C_AREF, 13'h000);
    expect_cmd(p + 13, C_MRS,  mr);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc - base, act, req);
    end
  endtask

  task automatic wait_to(input int k);
    while (cyc < base + k) @(negedge clk);
  endtask

  // Monitor: every non-NOP command must match the head of the scoreboard.
  logic [2:0] mon_cmd;
  exp_t       mon_e;
  always @(negedge clk) begin
    mon_cmd = {ras, cas, we};
    if (!rst) begin
      while (sbq.size() > 0 && sbq[0].at < cyc) begin
        checks++; failures++;
        $display("FAIL missed_cmd at=%0d required cmd=%b addr=%h", sbq[0].at - base, sbq[0].cmd, sbq[0].addr);
        sbq.delete(0);
      end
      checks++;
      if (mon_cmd != C_NOP) begin
        if (sbq.size() == 0 || sbq[0].at != cyc) begin
          failures++;
          $display("FAIL unexpected_cmd cyc=%0d actual cmd=%b addr=%h required NOP", cyc - base, mon_cmd, addr);
        end else begin
          mon_e = sbq.pop_front();
          if (mon_cmd != mon_e.cmd || addr != mon_e.addr || ba != 2'd0) begin
            failures++;
            $display("FAIL cmd_fields cyc=%0d actual cmd=%b ba=%0d addr=%h required cmd=%b ba=0 addr=%h",
                     cyc - base, mon_cmd, ba, addr, mon_e.cmd, mon_e.addr);
          end
        end
      end else if (ba != 2'd0 || addr != 13'd0) begin
        failures++;
        $display("FAIL nop_bus cyc=%0d actual ba=%0d addr=%h required 0", cyc - base, ba, addr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cmd", {29'd0, ras, cas, we}, {29'd0, C_NOP});
    chk("rst_addr", {19'd0, addr}, 0);
    chk("rst_vld", bus_vld, 0);
    chk("rst_done", init_done, 0);
    chk("rst_req", ref_req, 0);
    chk("rst_urgent", ref_urgent, 0);
    chk("rst_pend", ref_pend, 0);

    // Power-up init
    rst = 1'b0;
    base = cyc + 1;
    expect_init(16, A_MR0);
    wait_to(15); chk("pwr_vld15", bus_vld, 0); chk("pwr_done15", init_done, 0);
    wait_to(16); chk("pwr_vld16", bus_vld, 1);
    wait_to(31); chk("pwr_vld31", bus_vld, 1); chk("pwr_done31", init_done, 0);
    wait_to(32); chk("pwr_vld32", bus_vld, 0); chk("pwr_done32", init_done, 1);
    chk("pwr_pend32", ref_pend, 0);

    // Re-init with a new mode
    mode = 4'b1011;
    wait_to(40);
    init_req = 1'b1;
    expect_init(41, A_MR1);
    @(negedge clk); init_req = 1'b0;
    chk("reinit_done41", init_done, 0); chk("reinit_vld41", bus_vld, 1);
    wait_to(56); chk("reinit_done56", init_done, 0);
    wait_to(57); chk("reinit_done57", init_done, 1); chk("reinit_vld57", bus_vld, 0);

    // Credits accumulate every 50 cycles after done and saturate at 4
    wait_to(106); chk("pend106", ref_pend, 0); chk("req106", ref_req, 0);
    wait_to(107); chk("pend107", ref_pend, 1); chk("req107", ref_req, 1); chk("urg107", ref_urgent, 0);
    wait_to(157); chk("pend157", ref_pend, 2);
    wait_to(207); chk("pend207", ref_pend, 3);
    wait_to(256); chk("pend256", ref_pend, 3); chk("urg256", ref_urgent, 0);
    wait_to(257); chk("pend257", ref_pend, 4); chk("urg257", ref_urgent, 1);
    wait_to(309); chk("pend309_sat", ref_pend, 4); chk("urg309", ref_urgent, 1);

    // Burst drain of four postponed refreshes
    wait_to(310);
    expect_cmd(311, C_PRE, A_PRE);
    expect_cmd(314, C_AREF, 13'h000);
    expect_cmd(319, C_AREF, 13'h000);
    expect_cmd(324, C_AREF, 13'h000);
    expect_cmd(329, C_AREF, 13'h000);
    ack = 1'b1;
    @(negedge clk); ack = 1'b0;
    chk("drain_vld311", bus_vld, 1);
    wait_to(315); chk("drain_pend315", ref_pend, 3); chk("drain_urg315", ref_urgent, 0);
    wait_to(333); chk("drain_vld333", bus_vld, 1); chk("drain_pend333", ref_pend, 0); chk("drain_req333", ref_req, 0);
    wait_to(334); chk("drain_vld334", bus_vld, 0); chk("drain_done334", init_done, 1);
    wait_to(356); chk("pend356", ref_pend, 0);
    wait_to(357); chk("pend357", ref_pend, 1); chk("req357", ref_req, 1);

    // Grant while the read/write engine owns the bus is ignored
    wait_to(370);
    rw_vld = 1'b1; ack = 1'b1;
    @(negedge clk); ack = 1'b0; rw_vld = 1'b0;
    wait_to(375); chk("rwvld_pend375", ref_pend, 1); chk("rwvld_vld375", bus_vld, 0);

    // Grant together with init request: init wins, pending kept
    wait_to(380);
    init_req = 1'b1; ack = 1'b1;
    expect_init(381, A_MR1);
    @(negedge clk); init_req = 1'b0; ack = 1'b0;
    chk("both_done381", init_done, 0); chk("both_vld381", bus_vld, 1); chk("both_pend381", ref_pend, 1);
    wait_to(396); chk("both_done396", init_done, 0);
    wait_to(397); chk("both_done397", init_done, 1); chk("both_pend397", ref_pend, 1);
    wait_to(446); chk("pend446", ref_pend, 1);
    wait_to(447); chk("pend447", ref_pend, 2);

    // Reset in the middle of a refresh wait
    wait_to(450);
    expect_cmd(451, C_PRE, A_PRE);
    expect_cmd(454, C_AREF, 13'h000);
    expect_cmd(459, C_AREF, 13'h000);
    ack = 1'b1;
    @(negedge clk); ack = 1'b0;
    wait_to(460); chk("mid_vld460", bus_vld, 1); chk("mid_pend460", ref_pend, 0);
    wait_to(461);
    rst = 1'b1;
    #1;
    chk("mid_rst_cmd", {29'd0, ras, cas, we}, {29'd0, C_NOP});
    chk("mid_rst_vld", bus_vld, 0);
    chk("mid_rst_done", init_done, 0);
    chk("mid_rst_addr", {19'd0, addr}, 0);
    chk("mid_rst_req", ref_req, 0);
    chk("mid_rst_urg", ref_urgent, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    base = cyc + 1;
    expect_init(16, A_MR1);
    wait_to(15); chk("post_vld15", bus_vld, 0);
    wait_to(16); chk("post_vld16", bus_vld, 1);
    wait_to(32); chk("post_done32", init_done, 1); chk("post_vld32", bus_vld, 0);
    wait_to(40);
    chk("sb_empty", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
